// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift-register command sequencer.
// The checker helpers are only exercised when SHIFT_SEQ_CHECK_EN is defined.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE,
    DONE
  } state_t;

  localparam int MAX_W = 32;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Zero-fill shift on a wide word; callers truncate to their own width.
  function automatic logic [MAX_W-1:0] expected_shift(input logic [MAX_W-1:0] data,
                                                      input logic dir,
                                                      input int unsigned count);
    return dir ? (data << count) : (data >> count);
  endfunction

endpackage

// File: rtl/shift_seq_checker.sv
// Self-check for the sequencer: predicts the shifted word at accept time and
// raises a sticky err if the register disagrees at capture. Used under SHIFT_SEQ_CHECK_EN.
module shift_seq_checker
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             capture,
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] sr_data,
  output logic             err
);

  logic [WIDTH-1:0] expected;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected <= '0;
      err      <= 1'b0;
    end else begin
      if (accept)
        expected <= WIDTH'(expected_shift(MAX_W'(data), dir, 32'(count)));
      if (capture && (sr_data != expected))
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer driving a parallel-load bidirectional shift register and
// returning the shifted word. Optional self-check enabled by SHIFT_SEQ_CHECK_EN.
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_count,
  output logic [WIDTH-1:0] par_in,
  output logic             we_n,
  output logic             direction,
  input  logic [WIDTH-1:0] sr_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             err
);

  state_t           state, next_state;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] counter_q;
  logic [WIDTH-1:0] res_q;
  logic             accept;
  logic [CNT_W-1:0] count_clamped;

  assign accept        = in_valid && (state == IDLE);
  assign count_clamped = (in_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : in_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = LOAD;
      LOAD:    next_state = (count_q == '0) ? CAPTURE : SHIFT;
      SHIFT:   if (counter_q == CNT_W'(1)) next_state = CAPTURE;
      CAPTURE: next_state = DONE;
      DONE:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result is sampled on the CAPTURE closing edge, before the register's next shift lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      dir_q     <= 1'b0;
      count_q   <= '0;
      counter_q <= '0;
      res_q     <= '0;
    end else begin
      if (accept) begin
        data_q  <= in_data;
        dir_q   <= in_dir;
        count_q <= count_clamped;
      end
      if (state == LOAD)
        counter_q <= count_q;
      else if (state == SHIFT)
        counter_q <= counter_q - CNT_W'(1);
      if (state == CAPTURE)
        res_q <= sr_data;
    end
  end

  assign in_ready  = (state == IDLE);
  assign we_n      = (state != LOAD);
  assign par_in    = data_q;
  assign direction = dir_q;
  assign res_valid = (state == DONE);
  assign res_data  = res_q;

`ifdef SHIFT_SEQ_CHECK_EN
  shift_seq_checker #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_checker (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept),
    .capture(state == CAPTURE),
    .data   (in_data),
    .dir    (in_dir),
    .count  (count_clamped),
    .sr_data(sr_data),
    .err    (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule
